// File: rtl/chunk_serial_adder_pkg.sv
// Shared types and sizing helpers for chunk_serial_adder.
package chunk_serial_adder_pkg;

  // Controller states: waiting for operands, adding chunks, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk counter width; kept at least one bit so CHUNK==WIDTH still has a counter.
  function automatic int calc_cnt_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_serial_adder_chunk_add.sv
// chunk_add: combinational CHUNK-bit ripple carry chain.
// c_msb is the carry into the top bit, used by the parent for signed overflow.
module chunk_add #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  // Bit-serial ripple through the chunk, remembering the carry entering the top bit.
  always_comb begin
    logic c;
    c     = cin;
    s     = '0;
    c_msb = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder: WIDTH-bit add/subtract computed CHUNK bits per clock,
// LSB chunk first, through a single shared chunk_add carry chain.
// Optional build macro CHUNK_SERIAL_ADDER_SAT_EN: saturate sum on signed overflow.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE and holds
// sum/cout/ovf stable until out_ready is seen. out_ready while out_valid=0 is ignored.
module chunk_serial_adder
  import chunk_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

`ifdef CHUNK_SERIAL_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic r_sign_a;
`endif

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_s;
  logic             w_co;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_sum_shift;

  chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .a     (r_a[CHUNK-1:0]),
    .b     (r_b[CHUNK-1:0]),
    .cin   (r_carry),
    .s     (w_s),
    .cout  (w_co),
    .c_msb (w_cmsb)
  );

  // New chunk enters the sum register from the MSB side.
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign w_sum_shift = w_s;
    end else begin : g_multi
      assign w_sum_shift = {w_s, r_sum[WIDTH-1:CHUNK]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    w_last    = (r_cnt == LAST_CNT);
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, per-chunk add and shift, final flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef CHUNK_SERIAL_ADDER_SAT_EN
      r_sign_a <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            // Subtraction is a + ~b + ~borrow, so invert B and the carry-in once here.
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
`ifdef CHUNK_SERIAL_ADDER_SAT_EN
            r_sign_a <= a[WIDTH-1];
`endif
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          r_sum   <= w_sum_shift;
          if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= w_co ^ w_cmsb;
`ifdef CHUNK_SERIAL_ADDER_SAT_EN
            // On overflow the true result has the sign of operand A.
            if (w_co ^ w_cmsb) r_sum <= r_sign_a ? SAT_MIN : SAT_MAX;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Self-checking bench for chunk_serial_adder (WIDTH=32, CHUNK=8).
module tb_chunk_serial_adder;

  localparam int W      = 32;
  localparam int C      = 8;
  localparam int NCHUNK = W / C;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  int checks;
  int errors;
  time last_accept_t;

  // Scoreboard: {cout, ovf, sum}
  logic [W+1:0] exp_q[$];

  chunk_serial_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the arithmetic definition: signed true value and unsigned borrow.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms, input logic mc);
    longint sa, sb, tv;
    logic [W:0] u;
    logic co, ov;
    logic [W-1:0] s;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    tv = ms ? (sa - sb - longint'(mc)) : (sa + sb + longint'(mc));
    ov = (tv > 64'sd2147483647) || (tv < -64'sd2147483648);
    s  = tv[W-1:0];
    if (!ms) begin
      u  = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
      co = u[W];
    end else begin
      co = ({1'b0, ma} >= ({1'b0, mb} + (W+1)'(mc)));
    end
`ifdef CHUNK_SERIAL_ADDER_SAT_EN
    if (ov) s = (tv < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {co, ov, s};
  endfunction

  // Reset driver
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full operation: accept, latency, back-pressure hold, release.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input logic tc, input int hold, input bit early_ready, input bit noise);
    int n;
    int lat;
    logic [W+1:0] e;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: in_ready=%b required 1 within 20 cycles", in_ready);
      return;
    end
    a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
    exp_q.push_back(model(ta, tb_v, ts, tc));
    @(posedge clk);
    last_accept_t = $time;
    @(negedge clk);
    in_valid  = noise;
    out_ready = early_ready;
    if (noise) begin
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    end
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid === 1'b1) break;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready: in_ready=%b required 0 at busy cycle %0d", in_ready, lat);
      end
    end
    checks++;
    if (lat != NCHUNK || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: got %0d cycles (out_valid=%b) required %0d", lat, out_valid, NCHUNK);
      exp_q.delete();
      in_valid = 1'b0; out_ready = 1'b0;
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if ({cout, ovf, sum} !== e) begin
      errors++;
      $display("FAIL result: a=%h b=%h sub=%b cin=%b got cout=%b ovf=%b sum=%h required cout=%b ovf=%b sum=%h",
               ta, tb_v, ts, tc, cout, ovf, sum, e[W+1], e[W], e[W-1:0]);
    end
    if (!early_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, ovf, sum} !== e) begin
          errors++;
          $display("FAIL hold: cycle %0d out_valid=%b in_ready=%b cout=%b ovf=%b sum=%h required 1 0 %b %b %h",
                   i, out_valid, in_ready, cout, ovf, sum, e[W+1], e[W], e[W-1:0]);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
  endtask

  task automatic test_directed();
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    // Ten stalled DONE cycles, with noisy inputs held valid throughout.
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 10, 1'b0, 1'b1);
  endtask

  task automatic test_ignore_out_ready();
    // out_ready already high while the result is still being computed.
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    // Previous op left cout=1 and ovf=1, so the reset visibly clears them.
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    run_op(32'hCAFE_0001, 32'h0000_FFFF, 1'b0, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    time t0;
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    t0 = last_accept_t;
    run_op(32'hFFFF_0000, 32'h0001_0000, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    checks++;
    if ((last_accept_t - t0) / 10 != NCHUNK + 2) begin
      errors++;
      $display("FAIL throughput: accept spacing %0d cycles required %0d",
               (last_accept_t - t0) / 10, NCHUNK + 2);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
        1: ra = 32'h8000_0000 + 32'($urandom_range(0, 3));
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_accept_t = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_out_ready();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
